// File: rtl/axis_stim_pkg.sv
// Shared constants and helpers for the AXI4-Stream stimulus source.
// The LFSR taps encode x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
package axis_stim_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/axis_stim_lfsr.sv
// 16-bit Fibonacci LFSR used to throttle the stimulus source.
// Latency: q updates one clock after en; no backpressure, free-running while en is high.
// Backpressure: none; the LFSR never stalls.
module axis_stim_lfsr
    import axis_stim_pkg::*;
(
    input  logic        clk,
    input  logic        arstn,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_q <= LFSR_SEED;
        end else if (en) begin
            r_q <= {^(r_q & LFSR_TAPS), r_q[15:1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/axis_slave_stimulus.sv
// Deterministic AXI4-Stream packet source; every output comes straight from a register.
// Latency: first beat valid one edge after reset release; no bubble between accepted beats.
// Backpressure: a valid beat is held unchanged until tready; AXIS_STIM_THROTTLE_EN adds LFSR gaps.
module axis_slave_stimulus
    import axis_stim_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 14,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH   = 1,
    parameter int unsigned PACKET_BYTES = 64,
    parameter int unsigned NUM_PACKETS  = 0,
    parameter int unsigned DEST_VALUE   = 0
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_arstn,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
    output logic [BUS_WIDTH-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    output logic [DEST_WIDTH-1:0]  m_axis_tdest
);

    localparam int unsigned BEATS = ceil_div(PACKET_BYTES, BUS_WIDTH);
    localparam int unsigned REM   = PACKET_BYTES - (BEATS - 1) * BUS_WIDTH;

    logic                   r_tvalid;
    logic [BUS_WIDTH*8-1:0] r_tdata;
    logic [BUS_WIDTH-1:0]   r_tkeep;
    logic                   r_tlast;
    logic [USER_WIDTH-1:0]  r_tuser;
    logic [DEST_WIDTH-1:0]  r_tdest;
    // Counters name the next beat to be offered, so they step when a beat is loaded.
    logic [31:0]            r_beat;
    logic [31:0]            r_pkt;
    logic                   r_done;

    logic                   w_slot;
    logic                   w_take;
    logic                   w_load;
    logic                   w_last;
    logic                   w_sop;
    logic [BUS_WIDTH*8-1:0] w_dat;
    logic [BUS_WIDTH-1:0]   w_keep;

`ifdef AXIS_STIM_THROTTLE_EN
    logic [15:0] w_lfsr;

    axis_stim_lfsr u_lfsr (
        .clk   (m_axis_aclk),
        .arstn (m_axis_arstn),
        .en    (1'b1),
        .q     (w_lfsr)
    );

    assign w_slot = w_lfsr[0];
`else
    assign w_slot = 1'b1;
`endif

    assign w_take = !r_tvalid || m_axis_tready;
    assign w_load = !r_done && w_slot;

    always_comb begin
        w_last = (r_beat == BEATS - 1);
        w_sop  = (r_beat == 32'd0);
        w_keep = '0;
        w_dat  = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (!w_last || 32'(i) < REM) begin
                w_keep[i]      = 1'b1;
                w_dat[8*i +: 8] = 8'(r_pkt + r_beat * BUS_WIDTH + 32'(i));
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
        if (!m_axis_arstn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= '0;
            r_tdest  <= '0;
            r_beat   <= '0;
            r_pkt    <= '0;
            r_done   <= 1'b0;
        end else if (w_take) begin
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_dat;
                r_tkeep  <= w_keep;
                r_tlast  <= w_last;
                r_tuser  <= USER_WIDTH'(w_sop);
                r_tdest  <= DEST_WIDTH'(DEST_VALUE);
                if (w_last) begin
                    r_beat <= '0;
                    r_pkt  <= r_pkt + 32'd1;
                    if (NUM_PACKETS != 0 && r_pkt + 32'd1 == NUM_PACKETS) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_beat <= r_beat + 32'd1;
                end
            end else begin
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
                r_tkeep  <= '0;
                r_tlast  <= 1'b0;
                r_tuser  <= '0;
                r_tdest  <= '0;
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tdest  = r_tdest;

endmodule

// File: tb/tb_axis_slave_stimulus.sv
// Scoreboard bench for axis_slave_stimulus: default free-running source plus a NUM_PACKETS=2 instance.
module tb_axis_slave_stimulus;

    localparam int BEATS = 5;
    localparam int REM   = 8;

    logic         clk    = 1'b0;
    logic         arstn  = 1'b0;
    logic         tready = 1'b0;
    logic         tready2 = 1'b0;

    logic         tvalid,  tvalid2;
    logic [111:0] tdata,   tdata2;
    logic [13:0]  tkeep,   tkeep2;
    logic         tlast,   tlast2;
    logic [0:0]   tuser,   tuser2;
    logic [0:0]   tdest,   tdest2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [111:0] dat;
        logic [13:0]  keep;
        logic         last;
        logic         user;
    } beat_t;

    beat_t sb[$];

    always #5 clk = ~clk;

    axis_slave_stimulus dut (
        .m_axis_aclk   (clk),
        .m_axis_arstn  (arstn),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .m_axis_tdest  (tdest)
    );

    axis_slave_stimulus #(.NUM_PACKETS(2)) dut2 (
        .m_axis_aclk   (clk),
        .m_axis_arstn  (arstn),
        .m_axis_tvalid (tvalid2),
        .m_axis_tready (tready2),
        .m_axis_tdata  (tdata2),
        .m_axis_tkeep  (tkeep2),
        .m_axis_tlast  (tlast2),
        .m_axis_tuser  (tuser2),
        .m_axis_tdest  (tdest2)
    );

    function automatic beat_t make_beat(input int p, input int b);
        beat_t x;
        x.dat  = '0;
        x.keep = '0;
        for (int i = 0; i < 14; i++) begin
            if (b < BEATS - 1 || i < REM) begin
                x.keep[i]       = 1'b1;
                x.dat[8*i +: 8] = 8'((p + b * 14 + i) % 256);
            end
        end
        x.last = (b == BEATS - 1);
        x.user = (b == 0);
        return x;
    endfunction

    task automatic push_packets(input int p0, input int n);
        for (int p = p0; p < p0 + n; p++)
            for (int b = 0; b < BEATS; b++)
                sb.push_back(make_beat(p, b));
    endtask

    // Called on a falling edge; a beat seen valid with tready high transfers on the next rising edge.
    task automatic drain(input int n, input int budget, input string name);
        int    got = 0;
        int    cyc = 0;
        beat_t e;
        tready = 1'b1;
        while (got < n && cyc < budget) begin
            if (tvalid === 1'b1 && tready) begin
                e = sb.pop_front();
                got++;
                checks++;
                if (tdata !== e.dat) begin
                    errors++;
                    $display("FAIL %s tdata beat %0d: got %h expected %h", name, got, tdata, e.dat);
                end
                checks++;
                if (tkeep !== e.keep) begin
                    errors++;
                    $display("FAIL %s tkeep beat %0d: got %h expected %h", name, got, tkeep, e.keep);
                end
                checks++;
                if (tlast !== e.last) begin
                    errors++;
                    $display("FAIL %s tlast beat %0d: got %b expected %b", name, got, tlast, e.last);
                end
                checks++;
                if (tuser[0] !== e.user) begin
                    errors++;
                    $display("FAIL %s tuser beat %0d: got %b expected %b", name, got, tuser, e.user);
                end
                checks++;
                if (tdest !== 1'b0) begin
                    errors++;
                    $display("FAIL %s tdest beat %0d: got %b expected 0", name, got, tdest);
                end
            end
            @(negedge clk);
            cyc++;
        end
        tready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats expected %0d", name, got, n);
        end
    endtask

    task automatic wait_valid(input string name);
        int cyc = 0;
        while (tvalid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (tvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s wait for tvalid: got %b expected 1", name, tvalid);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({tvalid, tdata, tkeep, tlast, tuser, tdest} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got v=%b d=%h k=%h l=%b u=%b t=%b expected all 0",
                     name, tvalid, tdata, tkeep, tlast, tuser, tdest);
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        checks++;
        if (tvalid2 !== 1'b0 || tdata2 !== '0) begin
            errors++;
            $display("FAIL reset dut2: got v=%b d=%h expected 0", tvalid2, tdata2);
        end
        arstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_num_packets();
        int n  = 0;
        int nl = 0;
        tready2 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (tvalid2 === 1'b1 && tready2) begin
                n++;
                if (tlast2) nl++;
            end
            @(negedge clk);
        end
        tready2 = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL num_packets transfers: got %0d expected 10", n);
        end
        checks++;
        if (nl != 2) begin
            errors++;
            $display("FAIL num_packets tlast count: got %0d expected 2", nl);
        end
        checks++;
        if ({tvalid2, tdata2, tkeep2, tlast2, tuser2} !== '0) begin
            errors++;
            $display("FAIL num_packets idle: got v=%b d=%h k=%h expected 0", tvalid2, tdata2, tkeep2);
        end
    endtask

    task automatic test_basic();
        push_packets(0, 2);
        drain(10, 200, "basic");
    endtask

    task automatic test_backpressure();
        push_packets(2, 2);
        drain(2, 100, "bp_pre");
        wait_valid("bp");
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== sb[0].dat || tkeep !== sb[0].keep ||
                tlast !== sb[0].last || tuser[0] !== sb[0].user) begin
                errors++;
                $display("FAIL bp hold cycle %0d: got v=%b d=%h k=%h expected v=1 d=%h k=%h",
                         c, tvalid, tdata, tkeep, sb[0].dat, sb[0].keep);
            end
            @(negedge clk);
        end
        drain(8, 200, "bp_post");
    endtask

    task automatic test_wrap();
        push_packets(4, 253);
        drain(253 * BEATS, 10000, "wrap");
    endtask

    task automatic test_reset_mid();
        push_packets(257, 1);
        drain(2, 100, "mid_pre");
        wait_valid("mid");
        #2 arstn = 1'b0;
        #1 check_idle("mid_reset_async");
        sb.delete();
        @(negedge clk);
        check_idle("mid_reset_held");
        arstn = 1'b1;
        @(negedge clk);
        push_packets(0, 2);
        drain(10, 200, "mid_restart");
    endtask

    initial begin
        test_reset();
        test_num_packets();
        test_basic();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
